// File: rtl/truth_table_capture.sv
// Sweeps a 3-input combinational block through all eight input vectors,
// captures its response into a truth table and compares it with EXPECTED.
module truth_table_capture #(
    parameter int unsigned SETTLE   = 1,
    parameter logic [7:0]  EXPECTED = 8'h96
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a_o,
    output logic       b_o,
    output logic       c_o,
    input  logic       y_i,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] table_o,
    output logic [7:0] mismatch,
    output logic [3:0] fail_count
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state;
    logic [2:0] index;
    logic [3:0] settle_cnt;
    logic       y_bit;
    logic       miss;

    // An undriven or unknown response is recorded as a 0, never as a 1.
    assign y_bit = (y_i === 1'b1);
    assign miss  = y_bit ^ EXPECTED[index];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            index      <= 3'd0;
            settle_cnt <= 4'd0;
            a_o        <= 1'b0;
            b_o        <= 1'b0;
            c_o        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            table_o    <= 8'h00;
            mismatch   <= 8'h00;
            fail_count <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= DRIVE;
                        index      <= 3'd0;
                        settle_cnt <= 4'd0;
                        {a_o, b_o, c_o} <= 3'b000;
                        busy       <= 1'b1;
                        pass       <= 1'b0;
                        table_o    <= 8'h00;
                        mismatch   <= 8'h00;
                        fail_count <= 4'd0;
                    end
                end
                DRIVE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state      <= SAMPLE;
                        settle_cnt <= 4'd0;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                SAMPLE: begin
                    table_o[index]  <= y_bit;
                    mismatch[index] <= miss;
                    if (miss) begin
                        fail_count <= fail_count + 4'd1;
                    end
                    // The vector stays on the pins through SAMPLE so y_i is stable at the edge.
                    if (index == 3'd7) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (fail_count == 4'd0) && !miss;
                        {a_o, b_o, c_o} <= 3'b000;
                    end else begin
                        state <= DRIVE;
                        index <= index + 3'd1;
                        {a_o, b_o, c_o} <= index + 3'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    index <= 3'd0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_capture.sv
// Drives two captures (SETTLE=1 and SETTLE=3) through directed and random
// sweeps and checks them against a truth-table model built in the bench.
module tb_truth_table_capture;

    logic       clk = 1'b0;
    logic       rst;
    logic       start1, start3;
    logic       a1, b1, c1, y1, busy1, done1, pass1;
    logic       a3, b3, c3, y3, busy3, done3, pass3;
    logic [7:0] table1, mis1, table3, mis3;
    logic [3:0] fc1, fc3;

    int unsigned compared   = 0;
    int unsigned mismatched = 0;

    bit         sel;
    int         mode;
    logic [7:0] rand_tt;

    logic [2:0] o_abc;
    logic       o_busy, o_done, o_pass;
    logic [7:0] o_table, o_mis;
    logic [3:0] o_fc;

    always #5 clk = ~clk;

    truth_table_capture #(.SETTLE(1), .EXPECTED(8'h96)) u1 (
        .clk(clk), .rst(rst), .start(start1),
        .a_o(a1), .b_o(b1), .c_o(c1), .y_i(y1),
        .busy(busy1), .done(done1), .pass(pass1),
        .table_o(table1), .mismatch(mis1), .fail_count(fc1)
    );

    truth_table_capture #(.SETTLE(3), .EXPECTED(8'h96)) u3 (
        .clk(clk), .rst(rst), .start(start3),
        .a_o(a3), .b_o(b3), .c_o(c3), .y_i(y3),
        .busy(busy3), .done(done3), .pass(pass3),
        .table_o(table3), .mismatch(mis3), .fail_count(fc3)
    );

    // Behaviour of the block under test, chosen by mode.
    function automatic logic dut_fn(input int m, input logic [7:0] t, input logic [2:0] v);
        case (m)
            0: return v[2] ^ v[1] ^ v[0];
            1: return 1'b0;
            2: return v[2] & v[1];
            default: return t[v];
        endcase
    endfunction

    // Truth table the capture should produce, derived from arithmetic on the index.
    function automatic logic [7:0] ref_table(input int m, input logic [7:0] t);
        logic [7:0] r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            case (m)
                0: r[i] = ($countones(i) % 2) == 1;
                1: r[i] = 1'b0;
                2: r[i] = (i >= 6);
                default: r[i] = ((t >> i) & 8'h01) != 0;
            endcase
        end
        return r;
    endfunction

    assign y1 = dut_fn(mode, rand_tt, {a1, b1, c1});
    assign y3 = dut_fn(mode, rand_tt, {a3, b3, c3});

    always_comb begin
        o_abc   = sel ? {a3, b3, c3} : {a1, b1, c1};
        o_busy  = sel ? busy3  : busy1;
        o_done  = sel ? done3  : done1;
        o_pass  = sel ? pass3  : pass1;
        o_table = sel ? table3 : table1;
        o_mis   = sel ? mis3   : mis1;
        o_fc    = sel ? fc3    : fc1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_start(input logic v);
        start1 = sel ? 1'b0 : v;
        start3 = sel ? v : 1'b0;
    endtask

    // One sweep starting in the current cycle (cycle 0). abort_at>0 asserts rst in that cycle.
    task automatic applyStimulus(input bit use3, input int m, input logic [7:0] t,
                                 input bit repulse, input int abort_at);
        int p;
        int last;
        logic [7:0] exp_tbl;
        sel     = use3;
        mode    = m;
        rand_tt = t;
        p       = use3 ? 4 : 2;
        last    = 8 * p + 3;
        exp_tbl = ref_table(m, t);
        drive_start(1'b1);
        for (int c = 1; c <= last; c++) begin
            tick();
            drive_start(repulse && (c == 5 || c == 16));
            if (c <= 8 * p) begin
                checkOutput("abc_drive", 32'(o_abc), 32'((c - 1) / p));
                checkOutput("busy_sweep", 32'(o_busy), 32'd1);
                checkOutput("done_early", 32'(o_done), 32'd0);
            end else begin
                checkOutput("abc_idle", 32'(o_abc), 32'd0);
                checkOutput("busy_end", 32'(o_busy), 32'd0);
                checkOutput("done_pulse", 32'(o_done), 32'(c == 8 * p + 1));
            end
            if (abort_at > 0 && c == abort_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                drive_start(1'b0);
                checkOutput("abort_busy", 32'(o_busy), 32'd0);
                checkOutput("abort_abc", 32'(o_abc), 32'd0);
                checkOutput("abort_table", 32'(o_table), 32'd0);
                for (int k = 0; k < 12; k++) begin
                    checkOutput("abort_no_done", 32'(o_done), 32'd0);
                    tick();
                end
                return;
            end
        end
        checkOutput("table", 32'(o_table), 32'(exp_tbl));
        checkOutput("mismatch", 32'(o_mis), 32'(exp_tbl ^ 8'h96));
        checkOutput("fail_count", 32'(o_fc), 32'($countones(exp_tbl ^ 8'h96)));
        checkOutput("pass", 32'(o_pass), 32'(exp_tbl == 8'h96));
    endtask

    initial begin
        sel     = 1'b0;
        mode    = 0;
        rand_tt = 8'h00;
        start1  = 1'b0;
        start3  = 1'b0;
        rst     = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checkOutput("rst_busy1", 32'(busy1), 32'd0);
        checkOutput("rst_done1", 32'(done1), 32'd0);
        checkOutput("rst_table1", 32'(table1), 32'd0);
        checkOutput("rst_abc1", 32'({a1, b1, c1}), 32'd0);
        checkOutput("rst_pass3", 32'(pass3), 32'd0);
        checkOutput("rst_fc3", 32'(fc3), 32'd0);

        $display("[TB] parity loopback, SETTLE=1");
        applyStimulus(1'b0, 0, 8'h00, 1'b0, 0);
        $display("[TB] y tied low");
        applyStimulus(1'b0, 1, 8'h00, 1'b0, 0);
        $display("[TB] y = a & b");
        applyStimulus(1'b0, 2, 8'h00, 1'b0, 0);
        $display("[TB] start re-pulsed mid-sweep");
        applyStimulus(1'b0, 0, 8'h00, 1'b1, 0);
        $display("[TB] reset while index 3 is sampled");
        applyStimulus(1'b0, 3, 8'($urandom), 1'b0, 8);
        applyStimulus(1'b0, 0, 8'h00, 1'b0, 0);
        $display("[TB] parity loopback, SETTLE=3");
        applyStimulus(1'b1, 0, 8'h00, 1'b0, 0);
        $display("[TB] random response tables");
        for (int n = 0; n < 6; n++) begin
            applyStimulus(n >= 4, 3, 8'($urandom), 1'b0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
